lfsr_checker: RTL and testbench

Receive-side companion to the LFSR pseudo-random generator: consumes a word stream produced by that generator (over a link or loopback path), self-synchronises to it, and reports lock status and bit-pattern errors. Used for link BIST and loopback test of the Ethernet datapath. Any in-sequence word seeds it, so it needs no seed of its own. It uses the same feedback taps and shift direction as the generator.

---
 rtl/lfsr_checker.sv | 141 ++++++++++++++
 tb/tb_lfsr_checker.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// Receive-side LFSR pattern checker: self-seeds from any nonzero in-sequence word,
// tracks lock with a flywheel predictor and keeps saturating error/word statistics.
module lfsr_checker #(
  parameter int DATA_WIDTH = 8,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  input  logic                  clear_cnt,
  output logic                  locked,
  output logic                  err_pulse,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [CNT_WIDTH-1:0]  word_count
);

  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W  = $clog2(LOSS_COUNT + 1);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t                state_reg;
  logic [DATA_WIDTH-1:0] ref_reg;
  logic [MATCH_W-1:0]    match_cnt_reg;
  logic [MISS_W-1:0]     miss_cnt_reg;
  logic                  locked_reg;
  logic                  err_pulse_reg;

  logic                  fb;
  logic [DATA_WIDTH-1:0] pred_ref;
  logic                  din_match;
  logic                  din_zero;

  // Feedback taps must match the generator for the chosen word width.
  generate
    if (DATA_WIDTH == 8) begin : g_fb8
      assign fb = ref_reg[0] ^ ref_reg[2] ^ ref_reg[3] ^ ref_reg[4];
    end else if (DATA_WIDTH == 16) begin : g_fb16
      assign fb = ref_reg[0] ^ ref_reg[2] ^ ref_reg[3] ^ ref_reg[5];
    end else if (DATA_WIDTH == 32) begin : g_fb32
      assign fb = ref_reg[0] ^ ref_reg[10] ^ ref_reg[30] ^ ref_reg[31];
    end else begin : g_fbdef
      assign fb = ref_reg[0] ^ ref_reg[1];
    end
  endgenerate

  assign pred_ref  = {fb, ref_reg[DATA_WIDTH-1:1]};
  assign din_match = (din == pred_ref);
  assign din_zero  = (din == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= SEARCH;
      ref_reg       <= '0;
      match_cnt_reg <= '0;
      miss_cnt_reg  <= '0;
      locked_reg    <= 1'b0;
      err_pulse_reg <= 1'b0;
    end else begin
      err_pulse_reg <= 1'b0;
      if (din_valid) begin
        unique case (state_reg)
          SEARCH: begin
            // All-zero is the generator lock-up state, never a usable seed.
            if (!din_zero) begin
              ref_reg       <= din;
              match_cnt_reg <= '0;
              state_reg     <= ACQUIRE;
            end
          end
          ACQUIRE: begin
            if (din_match) begin
              ref_reg       <= din;
              match_cnt_reg <= match_cnt_reg + MATCH_W'(1);
              if (match_cnt_reg == MATCH_W'(LOCK_COUNT - 1)) begin
                state_reg    <= LOCKED;
                locked_reg   <= 1'b1;
                miss_cnt_reg <= '0;
              end
            end else if (!din_zero) begin
              ref_reg       <= din;
              match_cnt_reg <= '0;
            end else begin
              state_reg <= SEARCH;
            end
          end
          LOCKED: begin
            if (din_match) begin
              ref_reg      <= din;
              miss_cnt_reg <= '0;
            end else begin
              // Flywheel: advance on our own prediction so bad data never reseeds.
              err_pulse_reg <= 1'b1;
              ref_reg       <= pred_ref;
              miss_cnt_reg  <= miss_cnt_reg + MISS_W'(1);
              if (miss_cnt_reg == MISS_W'(LOSS_COUNT - 1)) begin
                state_reg  <= SEARCH;
                locked_reg <= 1'b0;
              end
            end
          end
          default: begin
            state_reg  <= SEARCH;
            locked_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  // Index 0 counts mismatches, index 1 counts every word compared while locked.
  logic [1:0] cnt_inc;
  assign cnt_inc[0] = din_valid && (state_reg == LOCKED) && !din_match;
  assign cnt_inc[1] = din_valid && (state_reg == LOCKED);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_WIDTH-1:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (rst || clear_cnt) begin
          cnt_reg <= '0;
        end else if (cnt_inc[gi] && (cnt_reg != '1)) begin
          cnt_reg <= cnt_reg + CNT_WIDTH'(1);
        end
      end
    end
  endgenerate

  assign err_count  = g_cnt[0].cnt_reg;
  assign word_count = g_cnt[1].cnt_reg;
  assign locked     = locked_reg;
  assign err_pulse  = err_pulse_reg;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker (8-bit taps, 4-bit counters so saturation is reachable).
module tb_lfsr_checker;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic          clear_cnt = 1'b0;
  logic          locked;
  logic          err_pulse;
  logic [CW-1:0] err_count;
  logic [CW-1:0] word_count;

  int vectors = 0;
  int miscompares = 0;

  // Hand-stepped generator sequence starting at seed 0x01.
  logic [7:0] seq [28] = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h88, 8'hC4, 8'hE2,
                           8'h71, 8'h38, 8'h1C, 8'h8E, 8'h47, 8'h23, 8'h91, 8'h48,
                           8'hA4, 8'hD2, 8'hE9, 8'h74, 8'h3A, 8'h1D, 8'h0E, 8'h07,
                           8'h03, 8'h81, 8'hC0, 8'h60};

  lfsr_checker #(
    .DATA_WIDTH(DW), .LOCK_COUNT(4), .LOSS_COUNT(3), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clear_cnt(clear_cnt),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .word_count(word_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] next_word(input logic [7:0] x);
    return {x[0] ^ x[2] ^ x[3] ^ x[4], x[7:1]};
  endfunction

  task automatic send(input logic [7:0] w, input logic v, input logic clr = 1'b0);
    @(negedge clk);
    din = w; din_valid = v; clear_cnt = clr;
    @(posedge clk);
    #1;
    din_valid = 1'b0; clear_cnt = 1'b0;
    $display("tx din=%02h valid=%0b clr=%0b -> locked=%0b err_pulse=%0b err_count=%0d word_count=%0d",
             w, v, clr, locked, err_pulse, err_count, word_count);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; din_valid = 1'b0; clear_cnt = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    $display("tx reset -> locked=%0b err_pulse=%0b err_count=%0d word_count=%0d",
             locked, err_pulse, err_count, word_count);
  endtask

  task automatic lock_up();
    for (int i = 0; i < 5; i++) send(seq[i], 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({locked, err_pulse, err_count, word_count} !== 10'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got l=%0b p=%0b e=%0d w=%0d, want all 0",
               locked, err_pulse, err_count, word_count);
    end
  endtask

  task automatic test_lock();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(seq[i], 1'b1);
      if (i == 3) begin
        vectors++;
        if (locked !== 1'b0) begin miscompares++; $display("FAIL lock_early: locked=%0b want 0", locked); end
      end
    end
    vectors++;
    if (locked !== 1'b1 || word_count !== 4'd0) begin
      miscompares++;
      $display("FAIL lock_rise: locked=%0b words=%0d want 1/0", locked, word_count);
    end
    send(seq[5], 1'b1);
    vectors++;
    if (word_count !== 4'd1 || err_count !== 4'd0 || err_pulse !== 1'b0 || locked !== 1'b1) begin
      miscompares++;
      $display("FAIL lock_first_word: l=%0b p=%0b e=%0d w=%0d want 1/0/0/1",
               locked, err_pulse, err_count, word_count);
    end
  endtask

  task automatic test_single_error();
    do_reset();
    lock_up();
    for (int i = 5; i < 10; i++) send(seq[i], 1'b1);
    send(seq[10] ^ 8'h01, 1'b1);
    vectors++;
    if (err_pulse !== 1'b1 || err_count !== 4'd1 || locked !== 1'b1) begin
      miscompares++;
      $display("FAIL single_err: p=%0b e=%0d l=%0b want 1/1/1", err_pulse, err_count, locked);
    end
    send(8'hFF, 1'b0);
    vectors++;
    if (err_pulse !== 1'b0) begin miscompares++; $display("FAIL pulse_gap: err_pulse=%0b want 0", err_pulse); end
    send(seq[11], 1'b1);
    vectors++;
    if (err_pulse !== 1'b0 || err_count !== 4'd1 || word_count !== 4'd7 || locked !== 1'b1) begin
      miscompares++;
      $display("FAIL flywheel: p=%0b e=%0d w=%0d l=%0b want 0/1/7/1",
               err_pulse, err_count, word_count, locked);
    end
  endtask

  task automatic test_loss();
    do_reset();
    lock_up();
    send(seq[5], 1'b1);
    send(seq[6] ^ 8'h01, 1'b1);
    send(seq[7] ^ 8'h02, 1'b1);
    vectors++;
    if (locked !== 1'b1 || err_pulse !== 1'b1) begin
      miscompares++;
      $display("FAIL loss_early: l=%0b p=%0b want 1/1", locked, err_pulse);
    end
    send(seq[8] ^ 8'h40, 1'b1);
    vectors++;
    if (locked !== 1'b0 || err_count !== 4'd3 || word_count !== 4'd4 || err_pulse !== 1'b1) begin
      miscompares++;
      $display("FAIL loss_drop: l=%0b e=%0d w=%0d p=%0b want 0/3/4/1",
               locked, err_count, word_count, err_pulse);
    end
    for (int i = 9; i < 14; i++) begin
      send(seq[i], 1'b1);
      if (i == 12) begin
        vectors++;
        if (locked !== 1'b0) begin miscompares++; $display("FAIL relock_early: locked=%0b want 0", locked); end
      end
    end
    vectors++;
    if (locked !== 1'b1 || err_count !== 4'd3 || word_count !== 4'd4) begin
      miscompares++;
      $display("FAIL relock: l=%0b e=%0d w=%0d want 1/3/4", locked, err_count, word_count);
    end
  endtask

  task automatic test_gaps();
    int gap [5] = '{2, 1, 3, 0, 4};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(seq[i], 1'b1);
      if (i == 3) begin
        vectors++;
        if (locked !== 1'b0) begin miscompares++; $display("FAIL gap_lock_early: locked=%0b want 0", locked); end
      end
      for (int g = 0; g < gap[i]; g++) send(8'hA5, 1'b0);
    end
    vectors++;
    if (locked !== 1'b1 || err_count !== 4'd0 || word_count !== 4'd0) begin
      miscompares++;
      $display("FAIL gap_lock: l=%0b e=%0d w=%0d want 1/0/0", locked, err_count, word_count);
    end
    send(seq[5], 1'b1);
    vectors++;
    if (word_count !== 4'd1 || err_count !== 4'd0) begin
      miscompares++;
      $display("FAIL gap_word: e=%0d w=%0d want 0/1", err_count, word_count);
    end
  endtask

  task automatic test_clear();
    do_reset();
    lock_up();
    send(seq[5], 1'b1);
    send(seq[6] ^ 8'h80, 1'b1, 1'b1);
    vectors++;
    if (err_pulse !== 1'b1 || err_count !== 4'd0 || word_count !== 4'd0 || locked !== 1'b1) begin
      miscompares++;
      $display("FAIL clear_same_cycle: p=%0b e=%0d w=%0d l=%0b want 1/0/0/1",
               err_pulse, err_count, word_count, locked);
    end
    send(seq[7], 1'b1);
    vectors++;
    if (word_count !== 4'd1 || err_count !== 4'd0 || err_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_after: p=%0b e=%0d w=%0d want 0/0/1", err_pulse, err_count, word_count);
    end
  endtask

  task automatic test_zero_and_midreset();
    do_reset();
    for (int i = 0; i < 6; i++) send(8'h00, 1'b1);
    vectors++;
    if (locked !== 1'b0) begin miscompares++; $display("FAIL zero_stream: locked=%0b want 0", locked); end
    send(8'h01, 1'b1);
    send(8'h00, 1'b1);
    for (int i = 1; i < 6; i++) begin
      send(seq[i], 1'b1);
      if (i == 4) begin
        vectors++;
        if (locked !== 1'b0) begin miscompares++; $display("FAIL zero_reseed_early: locked=%0b want 0", locked); end
      end
    end
    vectors++;
    if (locked !== 1'b1) begin miscompares++; $display("FAIL zero_reseed_lock: locked=%0b want 1", locked); end
    send(seq[6] ^ 8'h01, 1'b1);
    vectors++;
    if (err_pulse !== 1'b1 || err_count !== 4'd1) begin
      miscompares++;
      $display("FAIL pre_reset_err: p=%0b e=%0d want 1/1", err_pulse, err_count);
    end
    do_reset();
    vectors++;
    if ({locked, err_pulse, err_count, word_count} !== 10'b0) begin
      miscompares++;
      $display("FAIL midlock_reset: l=%0b p=%0b e=%0d w=%0d want all 0",
               locked, err_pulse, err_count, word_count);
    end
    for (int i = 0; i < 5; i++) begin
      send(seq[i], 1'b1);
      if (i == 3) begin
        vectors++;
        if (locked !== 1'b0) begin miscompares++; $display("FAIL post_reset_early: locked=%0b want 0", locked); end
      end
    end
    vectors++;
    if (locked !== 1'b1) begin miscompares++; $display("FAIL post_reset_lock: locked=%0b want 1", locked); end
  endtask

  task automatic test_saturation();
    logic [7:0] cur;
    do_reset();
    lock_up();
    cur = seq[4];
    for (int i = 0; i < 18; i++) begin
      cur = next_word(cur);
      send(cur ^ 8'h01, 1'b1);
      cur = next_word(cur);
      send(cur, 1'b1);
    end
    vectors++;
    if (err_count !== 4'hF || word_count !== 4'hF || locked !== 1'b1) begin
      miscompares++;
      $display("FAIL saturation: e=%0d w=%0d l=%0b want 15/15/1", err_count, word_count, locked);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_single_error();
    test_loss();
    test_gaps();
    test_clear();
    test_zero_and_midreset();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
